// File: rtl/parser_frame_controller.sv
// Frame sequencer for one AXI-Stream ingress port: header capture, decoder handoff, payload pass-through.
// Optional oversize detection is enabled by defining PARSER_CTRL_OVERSIZE_EN.
module parser_frame_controller #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned HEADER_BYTES    = 14,
    parameter int unsigned MAX_FRAME_BEATS = 1518,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  beat_accept,
    output logic                  frame_start,
    input  logic                  header_valid,
    output logic                  hdr_req,
    input  logic                  hdr_ack,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  runt_pulse,
    output logic                  oversize_pulse,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  runt_cnt
);
    localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int unsigned HDR_BEATS = (HEADER_BYTES + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;
    localparam int unsigned BCW = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [BCW-1:0] HDR_LAST = BCW'(HDR_BEATS - 1);
`ifdef PARSER_CTRL_OVERSIZE_EN
    localparam logic [BCW-1:0] LIMIT_LAST = BCW'(MAX_FRAME_BEATS - 1);
`endif

    typedef enum logic [2:0] {StStart, StHeader, StHold, StPayload, StDrop} state_e;

    state_e               state_q, state_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d, beat_cnt_inc;
    logic                 tlast_q, tlast_d;
    logic                 runt_set, frame_inc;
    logic                 runt_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q, runt_cnt_q;
`ifdef PARSER_CTRL_OVERSIZE_EN
    logic                 over_set, over_q;
`endif

    assign beat_cnt_inc = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
    assign beat_accept  = s_axis_tvalid & s_axis_tready;
    // Masked during reset so the restart pulse only fires once the block is live.
    assign frame_start  = (state_q == StStart) & ~rst;
    assign m_axis_tdata = s_axis_tdata;
    assign runt_pulse   = runt_q;
    assign frame_cnt    = frame_cnt_q;
    assign runt_cnt     = runt_cnt_q;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        tlast_d       = tlast_q;
        runt_set      = 1'b0;
        frame_inc     = 1'b0;
        s_axis_tready = 1'b0;
        hdr_req       = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
`ifdef PARSER_CTRL_OVERSIZE_EN
        over_set      = 1'b0;
`endif
        unique case (state_q)
            StStart: begin
                beat_cnt_d = '0;
                state_d    = StHeader;
            end
            StHeader: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (beat_cnt_q == HDR_LAST) begin
                        tlast_d = s_axis_tlast;
                        state_d = StHold;
                    end else if (s_axis_tlast) begin
                        runt_set = 1'b1;
                        state_d  = StStart;
                    end
                end
            end
            StHold: begin
                hdr_req = header_valid;
                if (header_valid && hdr_ack) begin
                    if (tlast_q) begin
                        frame_inc = 1'b1;
                        state_d   = StStart;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
`ifdef PARSER_CTRL_OVERSIZE_EN
                if (beat_cnt_q == LIMIT_LAST) m_axis_tlast = 1'b1;
`endif
                if (s_axis_tvalid && m_axis_tready) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (s_axis_tlast) begin
                        frame_inc = 1'b1;
                        state_d   = StStart;
                    end
`ifdef PARSER_CTRL_OVERSIZE_EN
                    else if (beat_cnt_q == LIMIT_LAST) begin
                        over_set = 1'b1;
                        state_d  = StDrop;
                    end
`endif
                end
            end
            StDrop: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = StStart;
            end
            default: state_d = StStart;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StStart;
            beat_cnt_q  <= '0;
            tlast_q     <= 1'b0;
            runt_q      <= 1'b0;
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            tlast_q    <= tlast_d;
            runt_q     <= runt_set;
            if (frame_inc && !(&frame_cnt_q)) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (runt_set && !(&runt_cnt_q)) runt_cnt_q <= runt_cnt_q + 1'b1;
        end
    end

`ifdef PARSER_CTRL_OVERSIZE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) over_q <= 1'b0;
        else     over_q <= over_set;
    end
    assign oversize_pulse = over_q;
`else
    assign oversize_pulse = 1'b0;
`endif

endmodule

// File: doc/parser_frame_controller.md
Name: parser_frame_controller

Overview:
Sequences the Ethernet header capture path for one AXI-Stream ingress port. It generates frame_start and beat_accept for the header shift register and stalls ingress while the captured header is handed to the decoder. It then forwards the payload beats downstream, and detects runt (and optionally oversize) frames. It sits between the MAC-side AXI-Stream slave and the header capture / payload output paths of the parser.

Parameters:
DATA_WIDTH, 8, ingress beat width in bits; multiple of 8
HEADER_BYTES, 14, header length captured per frame
MAX_FRAME_BEATS, 1518, oversize threshold in beats (used only with the optional feature)
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
s_axis_tdata  in  DATA_WIDTH  ingress data (to payload output and header shift register)
s_axis_tvalid  in  1  ingress valid
s_axis_tlast  in  1  ingress end of frame
s_axis_tready  out  1  ingress ready
beat_accept  out  1  s_axis_tvalid & s_axis_tready, to the header capture
frame_start  out  1  one-cycle restart pulse to the header capture
header_valid  in  1  header-complete flag from the header capture
hdr_req  out  1  header available to the decoder
hdr_ack  in  1  decoder has consumed the header
m_axis_tdata  out  DATA_WIDTH  payload data
m_axis_tvalid  out  1  payload valid
m_axis_tlast  out  1  payload end of frame
m_axis_tready  in  1  payload ready
runt_pulse  out  1  one-cycle pulse: frame ended before the header was complete
oversize_pulse  out  1  one-cycle pulse: frame exceeded MAX_FRAME_BEATS (tied 0 without the feature)
frame_cnt  out  CNT_WIDTH  frames completed normally, saturating
runt_cnt  out  CNT_WIDTH  runt frames, saturating

Behaviour:
- HDR_BEATS = ceil(HEADER_BYTES / (DATA_WIDTH/8)); the beat counter is $clog2(MAX_FRAME_BEATS+1) bits wide and saturates.
- States: START, HEADER, HOLD, PAYLOAD, DROP. Reset state is START.
- Reset values: all pulses 0, both counters 0, beat counter 0.
- START, lasting one cycle:
  - frame_start=1, s_axis_tready=0.
  - Next state HEADER, beat counter cleared.
  - START is the only state asserting frame_start, so frame_start never coincides with beat_accept.
- HEADER:
  - s_axis_tready=1; each accepted beat increments the beat counter.
  - Accepted beat with tlast and count+1 < HDR_BEATS: runt_pulse the next cycle, runt_cnt+1, go to START.
  - Accepted beat with count+1 == HDR_BEATS: go to HOLD, with tlast of that beat latched.
- HOLD:
  - s_axis_tready=0; hdr_req = header_valid.
  - On hdr_req & hdr_ack: if the latched tlast is set, go to START with frame_cnt+1; otherwise go to PAYLOAD.
  - hdr_ack while hdr_req=0 is ignored.
- PAYLOAD:
  - Pass-through: m_axis_tdata/tlast = s_axis_tdata/tlast, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready.
  - Zero added latency, no buffering.
  - On an accepted tlast beat: frame_cnt+1, go to START.
- DROP:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Discard beats until an accepted tlast, then go to START.
- m_axis_tvalid=0 in every state except PAYLOAD.
- beat_accept is combinational; the payload path and s_axis_tready are combinational from state.
- Counters saturate at all-ones and never wrap.
- rst asserted mid-frame:
  - Everything returns to START immediately (asynchronous).
  - The partial frame remainder is not dropped; upstream is responsible for flushing on reset.

Optional Feature:
Macro PARSER_CTRL_OVERSIZE_EN.
- Defined:
  - In PAYLOAD, when the accepted beat count reaches MAX_FRAME_BEATS without tlast, assert oversize_pulse for one cycle and go to DROP.
  - The beat that reaches the limit is forwarded with m_axis_tlast forced to 1.
  - frame_cnt is not incremented.
- Not defined: oversize_pulse is tied 0, DROP is unreachable, frames of any length pass.

Test Plan:
- Reset, then one 60-beat frame, m_axis_tready=1, hdr_ack 2 cycles after hdr_req -> frame_start one cycle after reset; tready=0 during HOLD; 46 payload beats out, the last with tlast; frame_cnt=1.
- 10-beat frame with tlast on beat 10 -> runt_pulse once, runt_cnt=1, no hdr_req, no m_axis_tvalid; frame_start pulses and the next frame parses normally.
- Exactly 14-beat frame -> hdr_req asserts; after hdr_ack the block returns to START with no payload beats; frame_cnt+1.
- 60-beat frame with m_axis_tready toggling every cycle -> s_axis_tready follows it; all 46 payload beats delivered in order, no duplicates.
- rst pulsed in PAYLOAD at beat 30 -> all outputs return to reset values; frame_start asserts one cycle after rst deasserts; counters are 0.
- PARSER_CTRL_OVERSIZE_EN with MAX_FRAME_BEATS=32 and a 40-beat frame -> beat 32 forwarded with tlast=1; oversize_pulse once; beats 33-40 dropped; frame_cnt unchanged.
